// File: rtl/jelly2_signal_arbiter_pkg.sv
// Shared sizing helpers and round-robin arithmetic for the signal-count arbiter.
package jelly2_signal_arbiter_pkg;

  localparam int MAX_CHANNELS    = 64;
  localparam int MAX_INDEX_WIDTH = 6;

  // Widest channel index any legal configuration can need.
  typedef logic [MAX_INDEX_WIDTH-1:0] index_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Search order position of channel idx when the last grant went to channel last.
  function automatic int rr_distance(input int idx, input int last, input int n);
    return (idx - last - 1 + 2 * n) % n;
  endfunction

endpackage

// File: rtl/jelly2_rr_select.sv
// Round-robin picker: purely combinational, nearest requester after the last grant wins.
module jelly2_rr_select
  import jelly2_signal_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] sel
);

  int best;

  assign any = |req;

  always_comb begin
    best = N;
    sel  = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (rr_distance(i, int'(last), N) < best)) begin
        best = rr_distance(i, int'(last), N);
        sel  = IW'(i);
      end
    end
  end

endmodule

// File: rtl/jelly2_signal_arbiter.sv
// Per-channel pending-signal counters shared round-robin onto one registered valid/ready port;
// 2-cycle pulse-to-offer latency, offered signal held stable under backpressure while counting continues.
module jelly2_signal_arbiter
  import jelly2_signal_arbiter_pkg::*;
#(
  parameter  int N              = 4,
  parameter  int CAPACITY_WIDTH = 8,
  localparam int INDEX_WIDTH    = clog2_min1(N)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N-1:0]           s_valid,
  input  logic [N-1:0]           s_enable,
  input  logic                   overflow_clear,
  output logic [N-1:0]           overflow,
  output logic                   m_valid,
  output logic [INDEX_WIDTH-1:0] m_index,
  input  logic                   m_ready
);

  typedef logic [CAPACITY_WIDTH-1:0] count_t;
  typedef logic [INDEX_WIDTH-1:0]    chan_t;

  localparam count_t COUNT_MAX = '1;

  count_t       count_q [N];
  count_t       count_d [N];
  logic [N-1:0] overflow_q, overflow_d;
  logic         m_valid_q, m_valid_d;
  chan_t        m_index_q, m_index_d;
  chan_t        last_q, last_d;

  logic [N-1:0] req;
  logic [N-1:0] dec_vec;
  logic         any;
  chan_t        sel;
  logic         load;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i] = s_enable[i] & (count_q[i] != '0);
    end
  end

  jelly2_rr_select #(.N(N)) u_rr_select (
    .req  (req),
    .last (last_q),
    .any  (any),
    .sel  (sel)
  );

  // The output slot refills whenever it is empty or being drained this cycle.
  assign load    = (!m_valid_q || m_ready) && any;
  assign dec_vec = load ? (N'(1) << sel) : '0;

  always_comb begin
    overflow_d = overflow_clear ? '0 : overflow_q;
    for (int i = 0; i < N; i++) begin
      count_d[i] = count_q[i];
      if (s_valid[i] && !dec_vec[i]) begin
        if (count_q[i] == COUNT_MAX) begin
          overflow_d[i] = 1'b1;
        end else begin
          count_d[i] = count_q[i] + 1'b1;
        end
      end else if (dec_vec[i] && !s_valid[i]) begin
        count_d[i] = count_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_index_d = m_index_q;
    last_d    = last_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_index_d = sel;
      last_d    = sel;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Reset parks the pointer on the last channel so channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        count_q[i] <= '0;
      end
      overflow_q <= '0;
      m_valid_q  <= 1'b0;
      m_index_q  <= '0;
      last_q     <= chan_t'(N - 1);
    end else begin
      for (int i = 0; i < N; i++) begin
        count_q[i] <= count_d[i];
      end
      overflow_q <= overflow_d;
      m_valid_q  <= m_valid_d;
      m_index_q  <= m_index_d;
      last_q     <= last_d;
    end
  end

  assign overflow = overflow_q;
  assign m_valid  = m_valid_q;
  assign m_index  = m_index_q;

endmodule

// File: tb/tb_jelly2_signal_arbiter.sv
// Directed and randomized checks of jelly2_signal_arbiter against a queue-based pending-count model.
module tb_jelly2_signal_arbiter;

  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int IW   = 2;
  localparam int MAXC = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  s_valid;
  logic [N-1:0]  s_enable;
  logic          overflow_clear;
  logic [N-1:0]  overflow;
  logic          m_valid;
  logic [IW-1:0] m_index;
  logic          m_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state: pending signals per channel, one offered slot, last granted channel.
  int           pend[$];
  logic [N-1:0] ovf_m;
  bit           mv_m;
  int           mi_m;
  int           last_m;

  always #5 clk = ~clk;

  jelly2_signal_arbiter #(.N(N), .CAPACITY_WIDTH(CW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .s_valid        (s_valid),
    .s_enable       (s_enable),
    .overflow_clear (overflow_clear),
    .overflow       (overflow),
    .m_valid        (m_valid),
    .m_index        (m_index),
    .m_ready        (m_ready)
  );

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int sel;
    logic [N-1:0] new_ovf;
    if (!reset_n) begin
      pend = {};
      for (int i = 0; i < N; i++) pend.push_back(0);
      ovf_m  = '0;
      mv_m   = 1'b0;
      mi_m   = 0;
      last_m = N - 1;
      return;
    end
    sel = -1;
    if (!mv_m || m_ready) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last_m + k) % N;
        if (sel < 0 && bit_of(s_enable, c) && pend[c] > 0) sel = c;
      end
    end
    new_ovf = overflow_clear ? '0 : ovf_m;
    for (int i = 0; i < N; i++) begin
      int v;
      v = pend[i] + int'(bit_of(s_valid, i)) - ((sel == i) ? 1 : 0);
      if (v > MAXC) begin
        v       = MAXC;
        new_ovf = new_ovf | (N'(1) << i);
      end
      pend[i] = v;
    end
    ovf_m = new_ovf;
    if (sel >= 0) begin
      mv_m   = 1'b1;
      mi_m   = sel;
      last_m = sel;
    end else if (m_ready) begin
      mv_m = 1'b0;
    end
  endtask

  // Advance one clock: predict, clock, then compare #1 after the edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".valid"}, m_valid, mv_m);
    if (mv_m) check({tag, ".index"}, m_index, mi_m);
    check({tag, ".ovf"}, overflow, ovf_m);
  endtask

  initial begin
    int issues;
    reset_n        = 1'b0;
    s_valid        = '1;
    s_enable       = '1;
    overflow_clear = 1'b0;
    m_ready        = 1'b1;

    // Reset with pulses applied: nothing may survive.
    tick("rst");
    tick("rst");
    check("rst_valid", m_valid, 0);
    check("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    s_valid = '0;
    repeat (4) begin
      tick("rst_idle");
      check("rst_idle_valid", m_valid, 0);
    end

    // Single pulse on channel 2: offered two cycles later for one cycle.
    s_valid = 4'b0100;
    tick("t2");
    s_valid = '0;
    check("t2_lat", m_valid, 0);
    tick("t2");
    check("t2_valid", m_valid, 1);
    check("t2_index", m_index, 2);
    tick("t2");
    check("t2_done", m_valid, 0);

    // Round-robin fairness from a fresh pointer.
    reset_n = 1'b0;
    tick("t3_rst");
    reset_n = 1'b1;
    s_valid = '1;
    tick("t3");
    check("t3_lat", m_valid, 0);
    for (int i = 0; i < 12; i++) begin
      if (i == 2) s_valid = '0;
      tick("t3");
      check("t3_valid", m_valid, 1);
      check("t3_index", m_index, i % 4);
    end
    tick("t3");
    check("t3_done", m_valid, 0);

    // Backpressure: offer held stable while more pulses accumulate.
    m_ready = 1'b0;
    s_valid = 4'b0010;
    tick("t4");
    s_valid = '0;
    tick("t4");
    check("t4_offer", m_valid, 1);
    check("t4_offer_idx", m_index, 1);
    for (int j = 0; j < 5; j++) begin
      s_valid = (j == 1 || j == 3) ? 4'b0010 : 4'b0000;
      tick("t4_hold");
      check("t4_hold_valid", m_valid, 1);
      check("t4_hold_idx", m_index, 1);
    end
    s_valid = '0;
    m_ready = 1'b1;
    tick("t4_drain");
    check("t4_drain1", m_valid, 1);
    check("t4_drain1_idx", m_index, 1);
    tick("t4_drain");
    check("t4_drain2", m_valid, 1);
    tick("t4_drain");
    check("t4_drain_end", m_valid, 0);

    // Saturation at 3 with channel 0 disabled, then drain and clear.
    s_enable = 4'b1110;
    for (int p = 0; p < 5; p++) begin
      s_valid = 4'b0001;
      tick("t5_fill");
      check("t5_fill_valid", m_valid, 0);
      if (p == 2) check("t5_ovf_pre", overflow, 0);
    end
    check("t5_ovf_set", overflow, 4'b0001);
    s_valid  = '0;
    s_enable = '1;
    issues   = 0;
    repeat (8) begin
      tick("t5_drain");
      if (m_valid) issues++;
    end
    check("t5_issues", issues, 3);
    check("t5_ovf_sticky", overflow, 4'b0001);
    overflow_clear = 1'b1;
    tick("t5_clr");
    overflow_clear = 1'b0;
    check("t5_ovf_clr", overflow, 0);

    // Clear and a new overflow on the same edge: the set must win.
    s_enable = 4'b1110;
    s_valid  = 4'b0001;
    repeat (3) tick("t5_refill");
    overflow_clear = 1'b1;
    tick("t5_setwins");
    overflow_clear = 1'b0;
    s_valid        = '0;
    check("t5_setwins", overflow, 4'b0001);

    // Continuous pulses on channel 3: one issue per cycle, then reset mid-stream.
    reset_n = 1'b0;
    tick("t6_rst");
    reset_n  = 1'b1;
    s_enable = '1;
    s_valid  = 4'b1000;
    tick("t6");
    check("t6_lat", m_valid, 0);
    repeat (10) begin
      tick("t6_stream");
      check("t6_stream_valid", m_valid, 1);
      check("t6_stream_idx", m_index, 3);
    end
    reset_n = 1'b0;
    tick("t6_midrst");
    check("t6_midrst_valid", m_valid, 0);
    tick("t6_midrst");
    reset_n = 1'b1;
    s_valid = '0;
    repeat (4) begin
      tick("t6_after");
      check("t6_after_valid", m_valid, 0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      s_valid        = N'($urandom & $urandom);
      s_enable       = ~N'($urandom & $urandom & $urandom);
      m_ready        = ($urandom_range(0, 3) != 0);
      overflow_clear = ($urandom_range(0, 15) == 0);
      reset_n        = ($urandom_range(0, 99) != 0);
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
